// File: rtl/bp_fe_bp_pkg.sv
// Shared predictor-side types and constants for the gshare update path.
// The entry struct depends on the index width, so it is declared through a macro.
`define BP_FE_BP_DECLARE_UPD_ENTRY_S(idx_width) \
    typedef struct packed { \
        logic [idx_width-1:0] idx; \
        logic                 pred; \
    } bp_fe_bp_upd_entry_s

package bp_fe_bp_pkg;
    localparam int bht_idx_width_gp  = 10;
    localparam int upd_queue_els_gp  = 8;
endpackage

// File: rtl/bp_fe_bp_upd_fifo_ctrl.sv
// Pointer/count bookkeeping for the update queue, including flush and sticky error.
module bp_fe_bp_upd_fifo_ctrl
    import bp_fe_bp_pkg::*;
#(
    parameter  int els_p        = upd_queue_els_gp,
    localparam int ptr_width_lp = $clog2(els_p),
    localparam int cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    alloc_v,
    input  logic                    resolve_v,
    input  logic                    flush,
    output logic                    ready,
    output logic                    alloc_acc,
    output logic                    resolve_acc,
    output logic [ptr_width_lp-1:0] rd_ptr,
    output logic [ptr_width_lp-1:0] wr_ptr,
    output logic [cnt_width_lp-1:0] count,
    output logic                    error
);
    logic                    full;
    logic                    empty;
    logic [ptr_width_lp-1:0] rd_ptr_next;

    assign full        = (count == cnt_width_lp'(els_p));
    assign empty       = (count == '0);
    assign ready       = ~full;
    assign alloc_acc   = alloc_v & ~full & ~flush;
    assign resolve_acc = resolve_v & ~empty;
    assign rd_ptr_next = rd_ptr + ptr_width_lp'(resolve_acc);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr_next;
            // Flush keeps the same-cycle resolve, then drops everything younger.
            if (flush) begin
                wr_ptr <= rd_ptr_next;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + ptr_width_lp'(alloc_acc);
                count  <= count + cnt_width_lp'(alloc_acc) - cnt_width_lp'(resolve_acc);
            end
            error <= error | (resolve_v & empty) | (alloc_v & full & ~flush);
        end
    end
endmodule

// File: rtl/bp_fe_bp_update_queue.sv
// In-order queue of outstanding predictions; retires each resolved branch into
// a registered gshare update (w_v/idx_w/correct).
module bp_fe_bp_update_queue
    import bp_fe_bp_pkg::*;
#(
    parameter  int bht_idx_width_p = bht_idx_width_gp,
    parameter  int els_p           = upd_queue_els_gp,
    localparam int ptr_width_lp    = $clog2(els_p),
    localparam int cnt_width_lp    = $clog2(els_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       alloc_v_i,
    output logic                       alloc_ready_o,
    input  logic [bht_idx_width_p-1:0] alloc_idx_i,
    input  logic                       alloc_pred_i,
    input  logic                       resolve_v_i,
    input  logic                       resolve_taken_i,
    input  logic                       flush_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_o,
    output logic [cnt_width_lp-1:0]    count_o,
    output logic                       error_o
);
    `BP_FE_BP_DECLARE_UPD_ENTRY_S(bht_idx_width_p);

    logic                    alloc_acc;
    logic                    resolve_acc;
    logic [ptr_width_lp-1:0] rd_ptr;
    logic [ptr_width_lp-1:0] wr_ptr;

    bp_fe_bp_upd_entry_s     mem [els_p];
    bp_fe_bp_upd_entry_s     rd_entry;

    bp_fe_bp_upd_fifo_ctrl #(.els_p(els_p)) ctrl (
        .clk         (clk_i),
        .reset_n     (reset_n_i),
        .alloc_v     (alloc_v_i),
        .resolve_v   (resolve_v_i),
        .flush       (flush_i),
        .ready       (alloc_ready_o),
        .alloc_acc   (alloc_acc),
        .resolve_acc (resolve_acc),
        .rd_ptr      (rd_ptr),
        .wr_ptr      (wr_ptr),
        .count       (count_o),
        .error       (error_o)
    );

    // Entry contents need no reset; count alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (alloc_acc)
            mem[wr_ptr] <= '{idx: alloc_idx_i, pred: alloc_pred_i};
    end

    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            w_v_o     <= 1'b0;
            idx_w_o   <= '0;
            correct_o <= 1'b0;
        end else begin
            w_v_o <= resolve_acc;
            if (resolve_acc) begin
                idx_w_o   <= rd_entry.idx;
                correct_o <= (rd_entry.pred == resolve_taken_i);
            end
        end
    end
endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Directed bench for the predictor update queue: queue-based model checked every
// cycle, plus literal expectations on the key scenarios.
module tb_bp_fe_bp_update_queue;
    logic       clk = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       alloc_v_i = 1'b0;
    logic       alloc_ready_o;
    logic [9:0] alloc_idx_i = '0;
    logic       alloc_pred_i = 1'b0;
    logic       resolve_v_i = 1'b0;
    logic       resolve_taken_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       w_v_o;
    logic [9:0] idx_w_o;
    logic       correct_o;
    logic [3:0] count_o;
    logic       error_o;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    bp_fe_bp_update_queue #(.bht_idx_width_p(10), .els_p(8)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .alloc_v_i       (alloc_v_i),
        .alloc_ready_o   (alloc_ready_o),
        .alloc_idx_i     (alloc_idx_i),
        .alloc_pred_i    (alloc_pred_i),
        .resolve_v_i     (resolve_v_i),
        .resolve_taken_i (resolve_taken_i),
        .flush_i         (flush_i),
        .w_v_o           (w_v_o),
        .idx_w_o         (idx_w_o),
        .correct_o       (correct_o),
        .count_o         (count_o),
        .error_o         (error_o)
    );

    always #5 clk = ~clk;

    // Reference: a plain queue of outstanding predictions.
    typedef struct { logic [9:0] idx; logic pred; } ent_t;
    ent_t       q[$];
    logic       m_w_v = 0;
    logic [9:0] m_idx = 0;
    logic       m_corr = 0;
    logic       m_err = 0;

    always @(posedge clk) begin
        if (!reset_n_i) begin
            q.delete();
            m_w_v = 0; m_idx = 0; m_corr = 0; m_err = 0;
        end else begin
            bit   ra, aa;
            ent_t e;
            ra = resolve_v_i && q.size() != 0;
            aa = alloc_v_i && q.size() != 8 && !flush_i;
            if (resolve_v_i && q.size() == 0) m_err = 1;
            if (alloc_v_i && q.size() == 8 && !flush_i) m_err = 1;
            m_w_v = ra;
            if (ra) begin
                e = q.pop_front();
                m_idx = e.idx;
                m_corr = (e.pred == resolve_taken_i);
            end
            if (flush_i) q.delete();
            else if (aa) q.push_back('{idx: alloc_idx_i, pred: alloc_pred_i});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("w_v",     32'(w_v_o),         32'(m_w_v));
            chk("idx_w",   32'(idx_w_o),       32'(m_idx));
            chk("correct", 32'(correct_o),     32'(m_corr));
            chk("count",   32'(count_o),       32'(q.size()));
            chk("ready",   32'(alloc_ready_o), 32'(q.size() != 8));
            chk("error",   32'(error_o),       32'(m_err));
        end
    end

    task automatic cyc(input logic av, input logic [9:0] ai, input logic ap,
                       input logic rv, input logic rt, input logic fl);
        alloc_v_i = av; alloc_idx_i = ai; alloc_pred_i = ap;
        resolve_v_i = rv; resolve_taken_i = rt; flush_i = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n_i = 0;
        cyc(0, 0, 0, 0, 0, 0);
        reset_n_i = 1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        started = 1;
        chk("rst_count", 32'(count_o), 0);
        chk("rst_wv",    32'(w_v_o), 0);
        chk("rst_ready", 32'(alloc_ready_o), 1);

        // single alloc then resolve
        cyc(1, 10'h155, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t1_wv",  32'(w_v_o), 1);
        chk("t1_idx", 32'(idx_w_o), 32'h155);
        chk("t1_cor", 32'(correct_o), 1);
        chk("t1_cnt", 32'(count_o), 0);

        // three in order
        cyc(1, 10'h001, 0, 0, 0, 0);
        cyc(1, 10'h002, 1, 0, 0, 0);
        cyc(1, 10'h003, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t2a_idx", 32'(idx_w_o), 1);  chk("t2a_cor", 32'(correct_o), 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t2b_idx", 32'(idx_w_o), 2);  chk("t2b_cor", 32'(correct_o), 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t2c_idx", 32'(idx_w_o), 3);  chk("t2c_cor", 32'(correct_o), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t2_wv_idle", 32'(w_v_o), 0);
        chk("t2_idx_hold", 32'(idx_w_o), 3);

        // fill, overflow, wrap
        for (int i = 0; i < 8; i++) cyc(1, 10'(10'h10 + i), 1'(i), 0, 0, 0);
        chk("t3_ready", 32'(alloc_ready_o), 0);
        chk("t3_cnt",   32'(count_o), 8);
        cyc(1, 10'h3FF, 1, 0, 0, 0);
        chk("t3_err", 32'(error_o), 1);
        chk("t3_cnt9", 32'(count_o), 8);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t3_idx", 32'(idx_w_o), 32'h10); chk("t3_cor", 32'(correct_o), 1);
        cyc(1, 10'h2A5, 1, 0, 0, 0);
        chk("t3_cnt_refill", 32'(count_o), 8);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 1, 0);
        chk("t3_wrap_idx", 32'(idx_w_o), 32'h2A5);
        chk("t3_wrap_cnt", 32'(count_o), 0);

        // flush with simultaneous resolve and alloc
        do_reset();
        chk("t4_err_clr", 32'(error_o), 0);
        for (int i = 0; i < 4; i++) cyc(1, 10'(10'h100 + i), 0, 0, 0, 0);
        cyc(1, 10'h3AA, 1, 1, 1, 1);
        chk("t4_wv",  32'(w_v_o), 1);
        chk("t4_idx", 32'(idx_w_o), 32'h100);
        chk("t4_cor", 32'(correct_o), 0);
        chk("t4_cnt", 32'(count_o), 0);
        chk("t4_err0", 32'(error_o), 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t4_err", 32'(error_o), 1);
        chk("t4_nowv", 32'(w_v_o), 0);

        // streaming alloc+resolve
        do_reset();
        cyc(1, 10'h050, 1, 0, 0, 0);
        cyc(1, 10'h051, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 10'(10'h200 + i), 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);
            chk("t5_cnt", 32'(count_o), 2);
            chk("t5_wv",  32'(w_v_o), 1);
        end

        // reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 10'(10'h0A0 + i), 1, 0, 0, 0);
        reset_n_i = 0;
        cyc(0, 0, 0, 1, 1, 0);
        reset_n_i = 1;
        chk("t6_wv",    32'(w_v_o), 0);
        chk("t6_cnt",   32'(count_o), 0);
        chk("t6_err",   32'(error_o), 0);
        chk("t6_ready", 32'(alloc_ready_o), 1);
        cyc(0, 0, 0, 0, 0, 0);

        started = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_fe_bp_update_queue.md
Name: bp_fe_bp_update_queue

Overview:
In-order tracking queue that sits directly upstream of the gshare predictor's update port.
- Captures each issued branch's raw BHT index and predicted direction at prediction time.
- Retires entries in program order when the backend resolves the branch, converting the actual direction into the predictor's write interface (w_v/idx_w/correct).
- Discards unresolved entries on a frontend flush.

Parameters:
bht_idx_width_p, 10, width of raw BHT index (matches predictor idx width)
els_p, 8, queue depth; power of 2, >= 2
localparam ptr_width_lp = $clog2(els_p); cnt_width_lp = $clog2(els_p+1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous, active-low reset
alloc_v_i  in  1  new prediction to record (valid)
alloc_ready_o  out  1  queue can accept (not full)
alloc_idx_i  in  bht_idx_width_p  raw index used for the prediction
alloc_pred_i  in  1  predicted direction (1 = taken)
resolve_v_i  in  1  oldest outstanding branch resolved this cycle
resolve_taken_i  in  1  actual direction of that branch
flush_i  in  1  squash all unresolved entries
w_v_o  out  1  predictor update valid
idx_w_o  out  bht_idx_width_p  predictor update index
correct_o  out  1  1 = stored prediction matched actual direction
count_o  out  cnt_width_lp  occupied entries
error_o  out  1  sticky: resolve on empty, or alloc while full

Behaviour:
- Storage: circular buffer of els_p entries {idx, pred}; rd_ptr, wr_ptr (ptr_width_lp, natural wrap), count register.
- Reset (reset_n_i == 0 at posedge): rd_ptr = wr_ptr = 0, count = 0, w_v_o = 0, idx_w_o = 0, correct_o = 0, error_o = 0. Entry contents are don't-care.
- Reset mid-operation discards all entries. No update is emitted for them.
- alloc_ready_o = (count != els_p), combinational from count.
- Alloc accepted iff alloc_v_i & alloc_ready_o & ~flush_i. Write at wr_ptr, then wr_ptr++.
- Resolve accepted iff resolve_v_i & (count != 0). The entry at rd_ptr is read and rd_ptr++.
- Update output is registered, latency 1: in the cycle after an accepted resolve:
  - w_v_o = 1
  - idx_w_o = entry.idx
  - correct_o = (entry.pred == resolve_taken_i)
- When no resolve is accepted, w_v_o = 0 and idx_w_o/correct_o hold their last values.
- Throughput: one alloc and one resolve per cycle. count_next = count + alloc_acc - resolve_acc.
- Full plus simultaneous resolve: alloc_ready_o is still 0 (no same-cycle bypass), so the alloc is not accepted that cycle.
- Flush:
  - The same-cycle resolve is processed first; the oldest entry still produces its update next cycle.
  - All remaining entries are then discarded: wr_ptr = rd_ptr_next, count = 0.
  - A same-cycle alloc is dropped and does not set error_o.
- Errors: resolve_v_i with count == 0, or alloc_v_i with count == els_p and no flush, sets error_o. It stays set until reset. The offending request has no other effect.
- Pointer wrap: pointers roll from els_p-1 to 0. Full and empty are distinguished by count, not by pointer equality.

Decomposition:
- Shared package bp_fe_bp_pkg holds:
  - typedef bp_fe_bp_upd_entry_s {logic [bht_idx_width_p-1:0] idx; logic pred;}, parameterised via a package macro.
  - the default bht_idx_width constant shared with the predictor.
- One natural sub-module: bp_fe_bp_upd_fifo_ctrl, holding pointers, count, full/empty and flush logic. Entry storage and update-output registers stay in the top module.

Test Plan:
- Reset, then alloc idx=0x155 pred=1; next cycle resolve taken=1 -> one cycle later w_v_o=1, idx_w_o=0x155, correct_o=1; count_o returns 0.
- Alloc 0x001 pred=0, 0x002 pred=1, 0x003 pred=1; resolve taken 1, 1, 0 in order -> updates (0x001, correct=0), (0x002, correct=1), (0x003, correct=0) on consecutive cycles.
- Fill 8 entries -> alloc_ready_o=0, count_o=8. Ninth alloc -> error_o=1, count_o stays 8. Resolve one; next cycle alloc succeeds; wr_ptr wraps to entry 0 correctly.
- 4 entries queued; same cycle: resolve taken=1, flush, alloc -> single update for the oldest entry, count_o=0, new alloc not stored. Next resolve -> error_o=1, no w_v_o.
- Continuous alloc+resolve every cycle for 20 cycles with random pred/taken -> count_o constant, w_v_o every cycle, correct_o matches scoreboard.
- reset_n_i low with 5 entries queued and a resolve in flight -> next cycle w_v_o=0, count_o=0, error_o=0, alloc_ready_o=1.
